// File: rtl/spu_pkg.sv
// Shared constants and types for the SPU even-pipe register-fetch stage.
//   REG_COUNT / WORD_W / ADDR_W : register table geometry
//   unit_t                      : execution unit encoding seen by EvenPipe
//   rf_state_t                  : register-fetch sequencer states
//   NOP_OP                      : opcode driven when no instruction issues
package spu_pkg;

  localparam int unsigned REG_COUNT = 128;
  localparam int unsigned WORD_W    = 128;
  localparam int unsigned ADDR_W    = 7;

  typedef enum logic [1:0] {
    UnitFp   = 2'd0,
    UnitFx2  = 2'd1,
    UnitByte = 2'd2,
    UnitFx1  = 2'd3
  } unit_t;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } rf_state_t;

  localparam logic [10:0] NOP_OP = 11'b0;

endpackage

// File: rtl/regfile_2w3r.sv
// SPU register table: REG_COUNT x WORD_W storage, two synchronous write
// ports (even, odd) and three asynchronous read ports.
// Optional macro: EVEN_RF_WB_BYPASS_EN forwards same-cycle write data to reads.
// Ports:
//   clk                              clock
//   we_even / addr_even / data_even  even write port
//   we_odd  / addr_odd  / data_odd   odd write port (wins on address collision)
//   ra_addr / rb_addr / rc_addr      read addresses
//   ra_data / rb_data / rc_data      read data
module regfile_2w3r
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              we_even,
  input  logic [ADDR_W-1:0] addr_even,
  input  logic [WORD_W-1:0] data_even,
  input  logic              we_odd,
  input  logic [ADDR_W-1:0] addr_odd,
  input  logic [WORD_W-1:0] data_odd,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] rc_addr,
  output logic [WORD_W-1:0] ra_data,
  output logic [WORD_W-1:0] rb_data,
  output logic [WORD_W-1:0] rc_data
);

  logic [WORD_W-1:0] mem [REG_COUNT];

  // Even write is dropped when the odd port targets the same entry.
  logic even_blocked;
  assign even_blocked = we_odd && (addr_odd == addr_even);

  always_ff @(posedge clk) begin
    if (we_even && !even_blocked) mem[addr_even] <= data_even;
    if (we_odd)                   mem[addr_odd]  <= data_odd;
  end

  always_comb begin
    ra_data = mem[ra_addr];
    rb_data = mem[rb_addr];
    rc_data = mem[rc_addr];
`ifdef EVEN_RF_WB_BYPASS_EN
    // Odd checks come last so they override even on a double match.
    if (we_even && addr_even == ra_addr) ra_data = data_even;
    if (we_even && addr_even == rb_addr) rb_data = data_even;
    if (we_even && addr_even == rc_addr) rc_data = data_even;
    if (we_odd && addr_odd == ra_addr)   ra_data = data_odd;
    if (we_odd && addr_odd == rb_addr)   rb_data = data_odd;
    if (we_odd && addr_odd == rc_addr)   rc_data = data_odd;
`endif
  end

endmodule

// File: rtl/even_reg_fetch.sv
// Register-fetch stage feeding EvenPipe. Owns the register table, clears it
// with a 128-cycle sweep after reset, then reads RA/RB/RC for each decoded
// even instruction and registers the EvenPipe input bundle (latency 1).
// Optional macro: EVEN_RF_WB_BYPASS_EN (writeback-to-read forwarding).
// Ports:
//   clk, reset (async, active-high)
//   dec_*      decoded instruction in; ready high once the sweep is done
//   op, format, unit, rt_addr, imm, reg_write, ra, rb, rc : EvenPipe bundle
//   wb_even_*, wb_odd_*  writeback ports (odd wins on collision)
module even_reg_fetch
  import spu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [10:0]       dec_op,
  input  logic [2:0]        dec_format,
  input  logic [1:0]        dec_unit,
  input  logic [ADDR_W-1:0] dec_rt_addr,
  input  logic [ADDR_W-1:0] dec_ra_addr,
  input  logic [ADDR_W-1:0] dec_rb_addr,
  input  logic [ADDR_W-1:0] dec_rc_addr,
  input  logic [17:0]       dec_imm,
  input  logic              dec_reg_write,
  output logic              ready,
  output logic [10:0]       op,
  output logic [2:0]        format,
  output logic [1:0]        unit,
  output logic [ADDR_W-1:0] rt_addr,
  output logic [WORD_W-1:0] ra,
  output logic [WORD_W-1:0] rb,
  output logic [WORD_W-1:0] rc,
  output logic [17:0]       imm,
  output logic              reg_write,
  input  logic [WORD_W-1:0] wb_even_data,
  input  logic [ADDR_W-1:0] wb_even_addr,
  input  logic              wb_even_we,
  input  logic [WORD_W-1:0] wb_odd_data,
  input  logic [ADDR_W-1:0] wb_odd_addr,
  input  logic              wb_odd_we
);

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              running;

  logic              rf_we_even;
  logic [ADDR_W-1:0] rf_addr_even;
  logic [WORD_W-1:0] rf_data_even;
  logic              rf_we_odd;
  logic [WORD_W-1:0] rd_a, rd_b, rd_c;

  assign running = (state == StRun);
  assign ready   = running;

  // The clear sweep borrows the even write port; writebacks are ignored
  // until the table is fully cleared.
  assign rf_we_even   = running ? wb_even_we   : 1'b1;
  assign rf_addr_even = running ? wb_even_addr : clr_cnt;
  assign rf_data_even = running ? wb_even_data : '0;
  assign rf_we_odd    = running && wb_odd_we;

  regfile_2w3r u_regfile (
    .clk       (clk),
    .we_even   (rf_we_even),
    .addr_even (rf_addr_even),
    .data_even (rf_data_even),
    .we_odd    (rf_we_odd),
    .addr_odd  (wb_odd_addr),
    .data_odd  (wb_odd_data),
    .ra_addr   (dec_ra_addr),
    .rb_addr   (dec_rb_addr),
    .rc_addr   (dec_rc_addr),
    .ra_data   (rd_a),
    .rb_data   (rd_b),
    .rc_data   (rd_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StInit;
      clr_cnt   <= '0;
      op        <= NOP_OP;
      format    <= '0;
      unit      <= '0;
      rt_addr   <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
    end else begin
      unique case (state)
        StInit: begin
          clr_cnt   <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(REG_COUNT - 1)) state <= StRun;
          op        <= NOP_OP;
          format    <= '0;
          unit      <= '0;
          rt_addr   <= '0;
          imm       <= '0;
          reg_write <= 1'b0;
          ra        <= '0;
          rb        <= '0;
          rc        <= '0;
        end
        StRun: begin
          if (dec_valid) begin
            op        <= dec_op;
            format    <= dec_format;
            unit      <= dec_unit;
            rt_addr   <= dec_rt_addr;
            imm       <= dec_imm;
            reg_write <= dec_reg_write;
            ra        <= rd_a;
            rb        <= rd_b;
            rc        <= rd_c;
          end else begin
            // Bubble: kill the op, keep operand registers stable.
            op        <= NOP_OP;
            imm       <= '0;
            reg_write <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_even_reg_fetch.sv
module tb_even_reg_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic         dec_valid;
  logic [10:0]  dec_op;
  logic [2:0]   dec_format;
  logic [1:0]   dec_unit;
  logic [6:0]   dec_rt_addr, dec_ra_addr, dec_rb_addr, dec_rc_addr;
  logic [17:0]  dec_imm;
  logic         dec_reg_write;
  logic         ready;
  logic [10:0]  op;
  logic [2:0]   format;
  logic [1:0]   unit;
  logic [6:0]   rt_addr;
  logic [127:0] ra, rb, rc;
  logic [17:0]  imm;
  logic         reg_write;
  logic [127:0] wb_even_data, wb_odd_data;
  logic [6:0]   wb_even_addr, wb_odd_addr;
  logic         wb_even_we, wb_odd_we;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  even_reg_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_op        (dec_op),
    .dec_format    (dec_format),
    .dec_unit      (dec_unit),
    .dec_rt_addr   (dec_rt_addr),
    .dec_ra_addr   (dec_ra_addr),
    .dec_rb_addr   (dec_rb_addr),
    .dec_rc_addr   (dec_rc_addr),
    .dec_imm       (dec_imm),
    .dec_reg_write (dec_reg_write),
    .ready         (ready),
    .op            (op),
    .format        (format),
    .unit          (unit),
    .rt_addr       (rt_addr),
    .ra            (ra),
    .rb            (rb),
    .rc            (rc),
    .imm           (imm),
    .reg_write     (reg_write),
    .wb_even_data  (wb_even_data),
    .wb_even_addr  (wb_even_addr),
    .wb_even_we    (wb_even_we),
    .wb_odd_data   (wb_odd_data),
    .wb_odd_addr   (wb_odd_addr),
    .wb_odd_we     (wb_odd_we)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [127:0] m_mem [128];
  int           m_init_left = 128;
  logic [10:0]  e_op = '0;
  logic [2:0]   e_fmt = '0;
  logic [1:0]   e_unit = '0;
  logic [6:0]   e_rt = '0;
  logic [17:0]  e_imm = '0;
  logic         e_rw = 1'b0;
  logic [127:0] e_ra = '0, e_rb = '0, e_rc = '0;
  logic         e_live = 1'b0;

  function automatic logic [127:0] model_read(input logic [6:0] a);
    logic [127:0] v;
    v = m_mem[a];
`ifdef EVEN_RF_WB_BYPASS_EN
    if (wb_odd_we && wb_odd_addr == a) v = wb_odd_data;
    else if (wb_even_we && wb_even_addr == a) v = wb_even_data;
`endif
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_init_left <= 128;
      e_op <= '0; e_fmt <= '0; e_unit <= '0; e_rt <= '0; e_imm <= '0; e_rw <= 1'b0;
      e_ra <= '0; e_rb <= '0; e_rc <= '0; e_live <= 1'b0;
    end else if (m_init_left > 0) begin
      m_mem[128 - m_init_left] <= '0;
      m_init_left <= m_init_left - 1;
    end else begin
      if (dec_valid) begin
        e_op <= dec_op; e_fmt <= dec_format; e_unit <= dec_unit; e_rt <= dec_rt_addr;
        e_imm <= dec_imm; e_rw <= dec_reg_write; e_live <= 1'b1;
        e_ra <= model_read(dec_ra_addr);
        e_rb <= model_read(dec_rb_addr);
        e_rc <= model_read(dec_rc_addr);
      end else begin
        e_op <= '0; e_imm <= '0; e_rw <= 1'b0; e_live <= 1'b0;
      end
      // Odd scheduled last: it wins a same-address collision.
      if (wb_even_we) m_mem[wb_even_addr] <= wb_even_data;
      if (wb_odd_we)  m_mem[wb_odd_addr]  <= wb_odd_data;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("ready", {127'b0, ready}, {127'b0, (m_init_left == 0) && !reset});
    check("op", {117'b0, op}, {117'b0, e_op});
    check("imm", {110'b0, imm}, {110'b0, e_imm});
    check("reg_write", {127'b0, reg_write}, {127'b0, e_rw});
    check("ra", ra, e_ra);
    check("rb", rb, e_rb);
    check("rc", rc, e_rc);
    if (e_live) begin
      check("format", {125'b0, format}, {125'b0, e_fmt});
      check("unit", {126'b0, unit}, {126'b0, e_unit});
      check("rt_addr", {121'b0, rt_addr}, {121'b0, e_rt});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    dec_valid = 0; dec_op = '0; dec_format = '0; dec_unit = '0; dec_rt_addr = '0;
    dec_ra_addr = '0; dec_rb_addr = '0; dec_rc_addr = '0; dec_imm = '0; dec_reg_write = 0;
    wb_even_we = 0; wb_even_addr = '0; wb_even_data = '0;
    wb_odd_we = 0; wb_odd_addr = '0; wb_odd_data = '0;
  endtask

  task automatic issue(input logic [10:0] o, input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] t, input logic [17:0] im,
                       input logic [2:0] f, input logic [1:0] u);
    dec_valid = 1; dec_op = o; dec_ra_addr = a; dec_rb_addr = b; dec_rc_addr = c;
    dec_rt_addr = t; dec_imm = im; dec_format = f; dec_unit = u; dec_reg_write = 1;
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!ready && n < 300) begin
      @(posedge clk);
      n++;
      #1;
    end
    check(name, 128'(n), 128'd128);
  endtask

  localparam logic [127:0] R3_VAL = 128'h00000025000100010001000100010001;
  localparam logic [127:0] R7_NEW = {{31{4'hF}}, 4'hE};

  initial begin
    reset = 1;
    idle();
    // Junk during the sweep must be ignored.
    issue(11'h155, 7'd9, 7'd9, 7'd9, 7'd9, 18'h3, 3'd2, 2'd1);
    wb_even_we = 1; wb_even_addr = 7'd9; wb_even_data = 128'hABC;
    #6 reset = 0;
    check("reset_op", {117'b0, op}, 128'd0);
    check("reset_ready", {127'b0, ready}, 128'd0);
    wait_init("init_len");
    idle();

    @(negedge clk);
    issue(11'h0AA, 7'd127, 7'd0, 7'd9, 7'd1, 18'h0, 3'd0, 2'd0);
    @(negedge clk);
    check("r127_zero", ra, 128'd0);
    check("r0_zero", rb, 128'd0);
    check("r9_init_gated", rc, 128'd0);
    idle();
    wb_even_we = 1; wb_even_addr = 7'd3; wb_even_data = R3_VAL;
    @(negedge clk);
    check("nop_op", {117'b0, op}, 128'd0);
    check("nop_rw", {127'b0, reg_write}, 128'd0);
    idle();
    issue(11'b01111000100, 7'd3, 7'd0, 7'd0, 7'd4, 18'h0, 3'd1, 2'd3);
    wb_even_we = 1; wb_even_addr = 7'd5; wb_even_data = 128'h1;
    wb_odd_we = 1;  wb_odd_addr = 7'd5;  wb_odd_data = 128'h2;
    @(negedge clk);
    check("mpy_op", {117'b0, op}, {117'b0, 11'b01111000100});
    check("mpy_ra", ra, R3_VAL);
    check("mpy_rt", {121'b0, rt_addr}, 128'd4);
    check("mpy_rw", {127'b0, reg_write}, 128'd1);
    idle();
    wb_even_we = 1; wb_even_addr = 7'd7; wb_even_data = 128'h77;
    @(negedge clk);
    idle();
    issue(11'h3, 7'd7, 7'd5, 7'd3, 7'd8, 18'h1F, 3'd3, 2'd2);
    wb_odd_we = 1; wb_odd_addr = 7'd7; wb_odd_data = R7_NEW;
    @(negedge clk);
`ifdef EVEN_RF_WB_BYPASS_EN
    check("bypass_ra", ra, R7_NEW);
`else
    check("nobypass_ra", ra, 128'h77);
`endif
    check("collision_r5", rb, 128'h2);
    check("imm_pass", {110'b0, imm}, 128'h1F);
    idle();

    // Mixed traffic, including same-cycle read/write and collisions.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      if (i % 3 != 2)
        issue(11'(i * 37 + 1), 7'(10 + i), 7'(9 + i), 7'(11 + i), 7'(i), 18'(i * 5),
              3'(i), 2'(i));
      wb_even_we = 1; wb_even_addr = 7'(10 + i); wb_even_data = {4{32'(i * 3 + 1)}};
      wb_odd_we = (i % 2 == 0); wb_odd_addr = 7'(10 + i + (i % 4 == 0 ? 0 : 1));
      wb_odd_data = ~{4{32'(i)}};
    end
    @(negedge clk);
    idle();
    @(negedge clk);

    // Reset while an instruction is issuing.
    issue(11'h7FF, 7'd3, 7'd3, 7'd3, 7'd3, 18'h3FFFF, 3'd7, 2'd3);
    #2 reset = 1;
    #1;
    check("mid_reset_op", {117'b0, op}, 128'd0);
    check("mid_reset_ra", ra, 128'd0);
    check("mid_reset_ready", {127'b0, ready}, 128'd0);
    @(negedge clk);
    #3 reset = 0;
    wait_init("reinit_len");
    idle();
    @(negedge clk);
    issue(11'h1, 7'd3, 7'd5, 7'd7, 7'd2, 18'h0, 3'd0, 2'd0);
    @(negedge clk);
    check("reinit_r3", ra, 128'd0);
    idle();
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/even_reg_fetch.md
Name: even_reg_fetch

Overview:
- Register-fetch (RF) stage directly upstream of EvenPipe.
- Holds the 128 x 128-bit SPU register table, written by the even and odd writeback ports.
- Reads RA/RB/RC for the decoded even-pipe instruction and registers op, format, unit, rt_addr, imm, reg_write, ra, rb and rc into the exact input bundle EvenPipe consumes.
- After reset it runs a sequential sweep that clears the table before accepting instructions.

Parameters:
- REG_COUNT, 128, number of architectural registers (power of two).
- WORD_W, 128, register width in bits.
- ADDR_W, 7, register address width; equals log2(REG_COUNT).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- dec_valid  in  1  decoded even instruction present
- dec_op  in  11  decoded opcode
- dec_format  in  3  instruction format
- dec_unit  in  2  execution unit: 0 FP, 1 FX2, 2 Byte, 3 FX1
- dec_rt_addr  in  7  destination register address
- dec_ra_addr / dec_rb_addr / dec_rc_addr  in  7 each  source register addresses
- dec_imm  in  18  immediate
- dec_reg_write  in  1  instruction writes RT
- ready  out  1  stage accepts dec_valid this cycle
- op  out  11  to EvenPipe
- format  out  3  to EvenPipe
- unit  out  2  to EvenPipe
- rt_addr  out  7  to EvenPipe
- ra / rb / rc  out  128 each  source values to EvenPipe
- imm  out  18  to EvenPipe
- reg_write  out  1  to EvenPipe
- wb_even_data  in  128  even writeback value (EvenPipe rt_wb)
- wb_even_addr  in  7  even writeback address
- wb_even_we  in  1  even writeback enable
- wb_odd_data  in  128  odd writeback value
- wb_odd_addr  in  7  odd writeback address
- wb_odd_we  in  1  odd writeback enable

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - state = INIT, clear counter = 0, ready = 0.
  - op, format, unit, rt_addr, imm, reg_write = 0.
  - ra, rb, rc = 0.
- State machine:
  - INIT: every cycle write 0 to entry[counter] and increment the counter. At counter == 127 write the last entry, then go to RUN. INIT lasts exactly 128 cycles.
  - RUN: steady state; stays in RUN until reset.
- ready = (state == RUN). It is combinational from the state register and rises on the first RUN cycle.
- During INIT:
  - writeback ports are ignored;
  - dec_valid is ignored;
  - all outputs are held at NOP (all zero).
- Issue in RUN: latency 1. If dec_valid is high at edge N, then after edge N the outputs carry that instruction's fields and ra = entry[dec_ra_addr], rb = entry[dec_rb_addr], rc = entry[dec_rc_addr], with values read before edge N's writes.
- NOP insertion: if dec_valid is low in RUN, op, reg_write and imm go to 0 after the edge; ra, rb and rc hold their previous values.
- Writeback: on each edge in RUN, entry[wb_even_addr] is written when wb_even_we is high, and entry[wb_odd_addr] is written when wb_odd_we is high.
- Write collision (both enables high, same address): the odd port wins. The even write is dropped silently.
- Address 0 is an ordinary writable register; it has no hard-wired zero.
- Reset asserted mid-operation: everything returns to reset values immediately and the INIT sweep restarts from 0. Table contents are undefined until that sweep completes.

Optional Feature:
- Macro: EVEN_RF_WB_BYPASS_EN.
- Defined: a read address equal to a same-cycle writeback address with its enable high takes the incoming wb data instead of the stale table value. If both ports match, odd data is used, per the collision rule. This applies to ra, rb and rc independently.
- Not defined: reads return the pre-write table value. A consumer must be at least one cycle after the writeback.

Decomposition:
- Package spu_pkg:
  - REG_COUNT, WORD_W, ADDR_W;
  - unit encoding typedef: FP, FX2, BYTE, FX1;
  - rf_state_t enum: INIT, RUN;
  - NOP opcode constant (11'b0).
- Sub-module regfile_2w3r:
  - storage array with 2 write ports and 3 asynchronous read ports;
  - odd-over-even priority;
  - bypass under EVEN_RF_WB_BYPASS_EN.
- even_reg_fetch owns the FSM, the clear counter and the output pipeline register.

Test Plan:
- Init sweep: assert reset, release at 6ns. ready = 0 for exactly 128 edges, then 1. A subsequent read of ra_addr 127 and rb_addr 0 returns 0 for both.
- Basic issue: write r3 = 128'h00000025000100010001000100010001 via the even port. Next cycle issue mpy (op 11'b01111000100) with ra_addr 3, rt_addr 4. One edge later op = 11'b01111000100, ra = written value, rt_addr = 4, reg_write = 1.
- Collision: even writes r5 = 128'h1 and odd writes r5 = 128'h2 on the same edge. A later read of r5 returns 128'h2.
- Bypass with macro: odd writes r7 = 128'hFFFF...FE on the same edge that an instruction reads ra_addr 7. With EVEN_RF_WB_BYPASS_EN, ra = 128'hFFFF...FE. Without it, ra = the prior value.
- NOP and INIT gating:
  - dec_valid low in RUN: op = 0, reg_write = 0 after the edge.
  - Writeback with wb_even_we = 1 during INIT: no effect; the register reads 0 after INIT.
- Mid-run reset: assert reset while issuing. All outputs are 0 immediately, ready drops, and the 128-cycle sweep repeats.
